countdown_timer_100hz: RTL and testbench

Down-counting companion to the stopwatch up-counter. It counts a loaded preset (0..9999) down to zero at 100 Hz, in 0.01 s units. The 14-bit count feeds the existing fnd_controller bcd input. It has an internal prescaler, a run/pause/done FSM, and a done flag for buzzer/LED use.

---
 rtl/countdown_timer_100hz.sv | 109 ++++++++++
 tb/tb_countdown_timer_100hz.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_100hz.sv
// Preset countdown at TICK_HZ with run/pause/done control.
// Count feeds the fnd_controller bcd input; o_done drives buzzer/LED.
module countdown_timer_100hz #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int TICK_HZ   = 100,
   parameter int MAX_COUNT = 9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_run_stop,
   input  logic        i_clear,
   input  logic        i_load,
   input  logic [13:0] i_load_value,
   output logic [13:0] o_count,
   output logic        o_tick,
   output logic        o_running,
   output logic        o_done
);

   localparam int DIV = CLK_FREQ / TICK_HZ;
   localparam int PW  = $clog2(DIV);

   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
   localparam logic [13:0]   MAXV = 14'(MAX_COUNT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [PW-1:0] presc;
   logic          term;
   logic          load_ok;
   logic [13:0]   load_sat;

   assign term     = (state == RUN) && (presc == PMAX);
   assign load_ok  = i_load && (state != RUN);
   assign load_sat = (i_load_value > MAXV) ? MAXV : i_load_value;

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (i_run_stop && (o_count != 14'd0))
               state_n = RUN;
         end
         RUN: begin
            if (term && (o_count == 14'd1))
               state_n = DONE;
            else if (!i_run_stop)
               state_n = PAUSE;
         end
         PAUSE: begin
            if (i_run_stop)
               state_n = RUN;
         end
         default: state_n = DONE;
      endcase
      if (load_ok)
         state_n = IDLE;
      if (i_clear)
         state_n = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         o_count   <= 14'd0;
         presc     <= '0;
         o_tick    <= 1'b0;
         o_running <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         state     <= state_n;
         o_running <= (state_n == RUN);
         o_done    <= (state_n == DONE);
         o_tick    <= 1'b0;
         if (i_clear) begin
            o_count <= 14'd0;
            presc   <= '0;
         end else if (load_ok) begin
            o_count <= load_sat;
            presc   <= '0;
         end else begin
            case (state)
               RUN: begin
                  if (presc == PMAX) begin
                     presc <= '0;
                     // guard keeps the count from ever wrapping
                     if (o_count != 14'd0) begin
                        o_count <= o_count - 14'd1;
                        o_tick  <= 1'b1;
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
               PAUSE:   presc <= presc;
               default: presc <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer_100hz.sv
// Directed bench for countdown_timer_100hz at DIV=10.
// Expected values are hand-derived from the tick timing.
module tb_countdown_timer_100hz;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_run_stop;
   logic        i_clear;
   logic        i_load;
   logic [13:0] i_load_value;
   logic [13:0] o_count;
   logic        o_tick;
   logic        o_running;
   logic        o_done;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   countdown_timer_100hz #(
      .CLK_FREQ (1000),
      .TICK_HZ  (100),
      .MAX_COUNT(9999)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_run_stop  (i_run_stop),
      .i_clear     (i_clear),
      .i_load      (i_load),
      .i_load_value(i_load_value),
      .o_count     (o_count),
      .o_tick      (o_tick),
      .o_running   (o_running),
      .o_done      (o_done)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (!o_tick && n < 40);
   endtask

   int gap;
   int bad;

   initial begin
      reset        = 1'b1;
      i_run_stop   = 1'b0;
      i_clear      = 1'b0;
      i_load       = 1'b0;
      i_load_value = 14'd0;
      cyc(2);
      reset = 1'b0;
      check("rst_count", o_count, 0);
      check("rst_run", o_running, 0);
      check("rst_done", o_done, 0);

      // reset mid-RUN
      i_load = 1'b1; i_load_value = 14'd37;
      cyc(1);
      check("ld37", o_count, 37);
      i_load = 1'b0; i_run_stop = 1'b1;
      cyc(1);
      check("run37", o_running, 1);
      cyc(3);
      reset = 1'b1;
      cyc(1);
      check("mrst_count", o_count, 0);
      check("mrst_run", o_running, 0);
      check("mrst_done", o_done, 0);
      check("mrst_tick", o_tick, 0);
      cyc(1);
      reset = 1'b0; i_run_stop = 1'b0;
      cyc(1);
      check("post_rst_count", o_count, 0);

      // load 5 and count down to DONE
      i_load = 1'b1; i_load_value = 14'd5; i_run_stop = 1'b1;
      cyc(1);
      check("ld5_count", o_count, 5);
      check("ld5_idle", o_running, 0);
      i_load = 1'b0;
      cyc(1);
      check("ld5_run", o_running, 1);
      for (int k = 1; k <= 5; k++) begin
         wait_tick(gap);
         check($sformatf("t5_gap%0d", k), gap, 10);
         check($sformatf("t5_cnt%0d", k), o_count, 5 - k);
      end
      check("t5_done", o_done, 1);
      check("t5_notrun", o_running, 0);
      bad = 0;
      for (int i = 0; i < 55; i++) begin
         cyc(1);
         if (!o_done || o_tick || o_count != 0) bad++;
      end
      check("done_hold", bad, 0);

      // load from DONE with run_stop held: IDLE one cycle then RUN
      i_load = 1'b1; i_load_value = 14'd3;
      cyc(1);
      check("dld_count", o_count, 3);
      check("dld_done", o_done, 0);
      check("dld_idle", o_running, 0);
      i_load = 1'b0;
      cyc(1);
      check("dld_run", o_running, 1);

      // pause/resume: 14 RUN edges, pause, resume
      cyc(13);
      check("pr_cnt2", o_count, 2);
      i_run_stop = 1'b0;
      cyc(1);
      check("pr_pause", o_running, 0);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         if (o_tick || o_count != 2 || o_running) bad++;
      end
      check("pr_hold", bad, 0);
      i_run_stop = 1'b1;
      cyc(1);
      check("pr_resume", o_running, 1);
      wait_tick(gap);
      check("pr_gap", gap, 6);
      check("pr_cnt1", o_count, 1);
      wait_tick(gap);
      check("pr_gap2", gap, 10);
      check("pr_done", o_done, 1);

      // clear beats load in DONE
      i_clear = 1'b1; i_load = 1'b1; i_load_value = 14'd50;
      cyc(1);
      check("cl_count", o_count, 0);
      check("cl_done", o_done, 0);
      check("cl_run", o_running, 0);
      i_clear = 1'b0; i_load = 1'b0;
      cyc(2);
      check("cl_stay_idle", o_running, 0);

      // saturation and zero-load
      i_run_stop = 1'b0;
      i_load = 1'b1; i_load_value = 14'd12000;
      cyc(1);
      check("sat", o_count, 9999);
      i_load_value = 14'd0;
      cyc(1);
      check("ld0", o_count, 0);
      i_load = 1'b0; i_run_stop = 1'b1;
      cyc(3);
      check("z_run", o_running, 0);
      check("z_done", o_done, 0);
      check("z_count", o_count, 0);

      // load ignored during RUN
      i_run_stop = 1'b0;
      i_load = 1'b1; i_load_value = 14'd8;
      cyc(1);
      i_load = 1'b0; i_run_stop = 1'b1;
      cyc(1);
      wait_tick(gap);
      check("ir_cnt7", o_count, 7);
      cyc(2);
      i_load = 1'b1; i_load_value = 14'd50;
      cyc(1);
      check("ir_ignored", o_count, 7);
      check("ir_run", o_running, 1);
      i_load = 1'b0;
      wait_tick(gap);
      check("ir_gap", gap, 7);
      check("ir_cnt6", o_count, 6);

      // run_stop falls on the terminal-count edge at count 9
      i_run_stop = 1'b0;
      cyc(1);
      i_load = 1'b1; i_load_value = 14'd10;
      cyc(1);
      i_load = 1'b0; i_run_stop = 1'b1;
      cyc(1);
      wait_tick(gap);
      check("sm_cnt9", o_count, 9);
      cyc(9);
      i_run_stop = 1'b0;
      cyc(1);
      check("sm_cnt8", o_count, 8);
      check("sm_tick", o_tick, 1);
      check("sm_pause", o_running, 0);
      check("sm_ndone", o_done, 0);
      i_run_stop = 1'b1;
      cyc(1);
      wait_tick(gap);
      check("sm_presc0", gap, 10);
      check("sm_cnt7", o_count, 7);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
